rc5_decrypt: RTL and testbench

RC5_DECRYPT -- requirements
Module: rc5_decrypt

---
 rtl/rc5_decrypt.sv | 95 +++++++++
 tb/tb_rc5_decrypt.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rc5_decrypt.sv
// rtl/rc5_decrypt.sv - RC5 block decryption, one S-table word per two cycles
module rc5_decrypt #(
    parameter int W        = 32,
    parameter int R        = 12,
    parameter int T        = 2 * (R + 1),
    parameter int T_LENGTH = $clog2(T)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [2*W-1:0]      iCiphertext,
    input  logic [W-1:0]        iS_sub_i,
    output logic [T_LENGTH-1:0] oS_address,
    output logic [2*W-1:0]      oPlaintext,
    output logic                oBusy,
    output logic                oDone
);
    localparam int LG = $clog2(W);

    typedef enum logic [1:0] {IDLE, WAIT, CALC, DONE} state_t;

    state_t              state, state_next;
    logic [W-1:0]        a, b, a_next, b_next;
    logic [W-1:0]        diff_a, diff_b;
    logic [T_LENGTH-1:0] k;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LG-1:0] n);
        return W'({x, x} >> n);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iStart) state_next = WAIT;
            WAIT:    state_next = CALC;
            CALC:    state_next = (k == '0) ? DONE : WAIT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Odd k finishes the B half of a round, even k the A half; k = 1 and 0 are the
    // final whitening subtractions with no rotate/xor.
    always_comb begin
        diff_a = a - iS_sub_i;
        diff_b = b - iS_sub_i;
        a_next = a;
        b_next = b;
        if (k[0]) begin
            b_next = (k == T_LENGTH'(1)) ? diff_b : (rotr(diff_b, a[LG-1:0]) ^ a);
        end else begin
            a_next = (k == '0) ? diff_a : (rotr(diff_a, b[LG-1:0]) ^ b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a          <= '0;
            b          <= '0;
            k          <= '0;
            oS_address <= '0;
            oPlaintext <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        a          <= iCiphertext[2*W-1:W];
                        b          <= iCiphertext[W-1:0];
                        k          <= T_LENGTH'(T - 1);
                        oS_address <= T_LENGTH'(T - 1);
                    end
                end
                CALC: begin
                    a <= a_next;
                    b <= b_next;
                    if (k != '0) begin
                        k          <= k - T_LENGTH'(1);
                        oS_address <= k - T_LENGTH'(1);
                    end else begin
                        oPlaintext <= {a_next, b_next};
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy = (state != IDLE);
    assign oDone = (state == DONE);
endmodule

// File: tb/tb_rc5_decrypt.sv
// tb/tb_rc5_decrypt.sv - directed self-checking bench for rc5_decrypt
module tb_rc5_decrypt;
    localparam int W  = 32;
    localparam int R  = 12;
    localparam int T  = 26;
    localparam int TL = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iStart = 1'b0;
    logic [63:0]   iCiphertext = '0;
    logic [31:0]   iS_sub_i;
    logic [TL-1:0] oS_address;
    logic [63:0]   oPlaintext;
    logic          oBusy;
    logic          oDone;

    logic [31:0] ram  [T];
    logic [31:0] skey [T];
    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] pt1, pt2, pt3, ct1, ct2, ct3;

    localparam logic [63:0] KAT_CT = {32'hEEDBA521, 32'h6D8F4B15};

    always #5 clk = ~clk;

    always @(posedge clk) iS_sub_i <= ram[oS_address];

    rc5_decrypt #(.W(W), .R(R), .T(T), .T_LENGTH(TL)) dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iCiphertext(iCiphertext),
        .iS_sub_i(iS_sub_i), .oS_address(oS_address), .oPlaintext(oPlaintext),
        .oBusy(oBusy), .oDone(oDone)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        logic [63:0] t;
        t = {x, x} << n[4:0];
        return t[63:32];
    endfunction

    // Reference RC5 key expansion for the all-zero 16-byte key.
    task automatic key_schedule_zero();
        logic [31:0] l [4];
        logic [31:0] ka, kb, sum;
        int ii, jj;
        for (int i = 0; i < 4; i++) l[i] = '0;
        skey[0] = 32'hB7E15163;
        for (int i = 1; i < T; i++) skey[i] = skey[i-1] + 32'h9E3779B9;
        ka = '0; kb = '0; ii = 0; jj = 0;
        for (int s = 0; s < 3 * T; s++) begin
            ka = rotl(skey[ii] + ka + kb, 32'd3);
            skey[ii] = ka;
            sum = ka + kb;
            kb = rotl(l[jj] + sum, sum);
            l[jj] = kb;
            ii = (ii + 1) % T;
            jj = (jj + 1) % 4;
        end
    endtask

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [31:0] ea, eb;
        ea = pt[63:32] + skey[0];
        eb = pt[31:0] + skey[1];
        for (int i = 1; i <= R; i++) begin
            ea = rotl(ea ^ eb, eb) + skey[2*i];
            eb = rotl(eb ^ ea, ea) + skey[2*i+1];
        end
        return {ea, eb};
    endfunction

    // Entered at a negedge; starts a decryption and checks every cycle through DONE->IDLE.
    task automatic run(input logic [63:0] ct, input logic [63:0] exp_pt, input bit junk, input string tag);
        iCiphertext = ct;
        iStart = 1'b1;
        for (int n = 0; n <= 53; n++) begin
            @(negedge clk);
            iStart = junk && ((n + 1 == 10) || (n + 1 == 52) || (n + 1 == 53));
            iCiphertext = iStart ? ~ct : ct;
            if (n <= 51) begin
                check({tag, " addr"}, 64'(oS_address), 64'(25 - n / 2));
                check({tag, " busy/done"}, {62'd0, oBusy, oDone}, 64'b10);
            end else if (n == 52) begin
                check({tag, " busy/done at done"}, {62'd0, oBusy, oDone}, 64'b11);
                check({tag, " plaintext"}, oPlaintext, exp_pt);
                check({tag, " addr at done"}, 64'(oS_address), 64'd0);
            end else begin
                check({tag, " busy/done idle"}, {62'd0, oBusy, oDone}, 64'b00);
                check({tag, " plaintext held"}, oPlaintext, exp_pt);
                check({tag, " addr held"}, 64'(oS_address), 64'd0);
            end
        end
        iStart = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < T; i++) ram[i] = '0;
        #12;
        @(negedge clk);
        check("reset busy/done", {62'd0, oBusy, oDone}, 64'b00);
        check("reset addr", 64'(oS_address), 64'd0);
        check("reset plaintext", oPlaintext, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run(64'd0, 64'd0, 1'b0, "zero_table");

        key_schedule_zero();
        for (int i = 0; i < T; i++) ram[i] = skey[i];
        run(KAT_CT, 64'd0, 1'b0, "kat");

        pt1 = 64'h0123456789ABCDEF;
        ct1 = encrypt(pt1);
        run(ct1, pt1, 1'b1, "ignore_start");

        pt2 = 64'hDEADBEEF00C0FFEE;
        ct2 = encrypt(pt2);
        iCiphertext = ct2;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (19) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async reset busy/done", {62'd0, oBusy, oDone}, 64'b00);
        check("async reset addr", 64'(oS_address), 64'd0);
        check("async reset plaintext", oPlaintext, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            check("aborted busy/done", {62'd0, oBusy, oDone}, 64'b00);
        end
        run(KAT_CT, 64'd0, 1'b0, "kat_after_reset");

        pt3 = 64'h5555AAAA33331111;
        ct3 = encrypt(pt3);
        run(ct2, pt2, 1'b0, "b2b_first");
        run(ct3, pt3, 1'b0, "b2b_second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
